// File: rtl/two_way_wt_cache_if.sv
// CPU load/store port and main-memory port of the two-way write-through cache.
// master: CPU + memory side; slave: the cache.
interface two_way_wt_cache_if;
  logic         cpu_req;
  logic         cpu_rw;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready;
  logic         cpu_done;
  logic [31:0]  cpu_rdata;
  logic         mem_read_write;
  logic [9:0]   mem_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data;

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_read_data,
    input  cpu_ready, cpu_done, cpu_rdata, mem_read_write, mem_address, mem_write_data
  );

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_read_data,
    output cpu_ready, cpu_done, cpu_rdata, mem_read_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/two_way_wt_cache.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// 16-byte blocks, word0 in [127:96], index = addr[5:4], tag = addr[9:6].
// Memory commands are held stable for MEM_LAT cycles; a write drives the
// address/data one cycle before mem_read_write rises so they never change
// while a write is asserted.
// Optional macro CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module two_way_wt_cache #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned SETS    = 4
) (
  input  logic clk,
  input  logic rst_n,
  two_way_wt_cache_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 6 - IDX_W;
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {IDLE, COMPARE, MEM_RD, REFILL, MEM_WR, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [9:0]         addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mem_rw_q, mem_rw_d;
  logic [9:0]         mem_addr_q, mem_addr_d;
  logic [127:0]       mem_wdata_q, mem_wdata_d;

  logic               valid_q [SETS][2];
  logic [TAG_W-1:0]   tag_q   [SETS][2];
  logic [127:0]       data_q  [SETS][2];
  logic               lru_q   [SETS];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         word;
  logic               hit0, hit1, hit, hit_way, victim;
  logic               wr_hit_en, refill_en, lru_en, lru_val;

  function automatic logic [31:0] sel_word(input logic [127:0] blk, input logic [1:0] w);
    return blk[{~w, 5'd0} +: 32];
  endfunction

  // Lookup of the latched request against both ways of its set
  always_comb begin
    idx     = addr_q[4 +: IDX_W];
    tag     = addr_q[9 -: TAG_W];
    word    = addr_q[3:2];
    hit0    = valid_q[idx][0] && (tag_q[idx][0] == tag);
    hit1    = valid_q[idx][1] && (tag_q[idx][1] == tag);
    hit     = hit0 || hit1;
    hit_way = hit1;
    victim  = !valid_q[idx][0] ? 1'b0 : (!valid_q[idx][1] ? 1'b1 : lru_q[idx]);
  end

  // Next-state, datapath strobes and registered-output next values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_hit_en   = 1'b0;
    refill_en   = 1'b0;
    lru_en      = 1'b0;
    lru_val     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          rw_d    = bus.cpu_rw;
          wdata_d = bus.cpu_wdata;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (rw_q) begin
          wr_hit_en   = hit;
          lru_en      = hit;
          lru_val     = ~hit_way;
          cnt_d       = CNT_W'(MEM_LAT);
          mem_addr_d  = addr_q;
          mem_wdata_d = 128'(wdata_q) << {~word, 5'd0};
          state_d     = MEM_WR;
        end else if (hit) begin
          rdata_d = sel_word(data_q[idx][hit_way], word);
          lru_en  = 1'b1;
          lru_val = ~hit_way;
          state_d = DONE;
        end else begin
          cnt_d      = CNT_W'(MEM_LAT - 1);
          mem_addr_d = addr_q;
          state_d    = MEM_RD;
        end
      end
      MEM_RD: begin
        if (cnt_q == '0) state_d = REFILL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      REFILL: begin
        refill_en = 1'b1;
        lru_en    = 1'b1;
        lru_val   = ~victim;
        rdata_d   = sel_word(bus.mem_read_data, word);
        state_d   = DONE;
      end
      MEM_WR: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d  = (state_d == IDLE);
    done_d   = (state_d == DONE);
    // First MEM_WR cycle is address/data setup; the next MEM_LAT cycles assert the write
    mem_rw_d = (state_d == MEM_WR) && (cnt_d != CNT_W'(MEM_LAT));
  end

  // FSM, latched request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Valid/tag/LRU state; cleared on reset so an aborted refill leaves nothing valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SETS); s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
        end
      end
    end else begin
      if (refill_en) begin
        valid_q[idx][victim] <= 1'b1;
        tag_q[idx][victim]   <= tag;
      end
      if (lru_en) lru_q[idx] <= lru_val;
    end
  end

  // Block storage: whole-block refill or single-word write-hit update
  always_ff @(posedge clk) begin
    if (refill_en)      data_q[idx][victim] <= bus.mem_read_data;
    else if (wr_hit_en) data_q[idx][hit_way][{~word, 5'd0} +: 32] <= wdata_q;
  end

  assign bus.cpu_ready      = ready_q;
  assign bus.cpu_done       = done_q;
  assign bus.cpu_rdata      = rdata_q;
  assign bus.mem_read_write = mem_rw_q;
  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating per-access hit/miss counters, stepped once in COMPARE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == COMPARE) begin
      if (hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else if (miss_cnt_q != 16'hFFFF) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_two_way_wt_cache.sv
// Bench for two_way_wt_cache: combinational main memory preloaded mem[i]=i+1,
// a recency-list reference model of the cache, directed and random accesses.
module tb_two_way_wt_cache;
  localparam int unsigned MEM_LAT = 2;

  logic clk;
  logic rst_n;
  two_way_wt_cache_if bus();
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  two_way_wt_cache #(.MEM_LAT(MEM_LAT), .SETS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          occ [4];
  logic [3:0]  mru [4];
  logic [3:0]  lru [4];
  int          n_hit, n_miss;
  int          rw_hi_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational block read, word0 in the top bits
  assign bus.mem_read_data = {mem[{bus.mem_address[9:4], 2'd0}], mem[{bus.mem_address[9:4], 2'd1}],
                              mem[{bus.mem_address[9:4], 2'd2}], mem[{bus.mem_address[9:4], 2'd3}]};

  // Memory: preload, then a word write on every rising edge with mem_read_write=1
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    forever begin
      @(posedge clk);
      if (bus.mem_read_write === 1'b1) begin
        rw_hi_cnt <= rw_hi_cnt + 1;
        mem[bus.mem_address[9:2]] <= bus.mem_write_data[{~bus.mem_address[3:2], 5'd0} +: 32];
      end
    end
  end

  task automatic model_reset();
    for (int s = 0; s < 4; s++) occ[s] = 0;
    n_hit  = 0;
    n_miss = 0;
  endtask

  // Reference: each set is a 2-entry recency list; reads allocate, writes never do
  task automatic model(input bit rw, input logic [9:0] a, input logic [31:0] wd,
                       output bit hit, output logic [31:0] rd);
    int s;
    logic [3:0] t;
    s = int'(a[5:4]);
    t = a[9:6];
    hit = 1'b0;
    if (occ[s] >= 1 && mru[s] == t) begin
      hit = 1'b1;
    end else if (occ[s] == 2 && lru[s] == t) begin
      hit = 1'b1;
      lru[s] = mru[s];
      mru[s] = t;
    end else if (!rw) begin
      lru[s] = mru[s];
      mru[s] = t;
      if (occ[s] < 2) occ[s]++;
    end
    if (rw) ref_mem[a[9:2]] = wd;
    rd = ref_mem[a[9:2]];
    if (hit) n_hit++;
    else     n_miss++;
  endtask

  // One CPU access from a negedge; lat = accept edge to the edge that samples cpu_done
  task automatic access(input bit rw, input logic [9:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output int rwc, output bit to);
    int k;
    int rw0;
    to = 1'b0; lat = 0; rd = '0; rwc = 0;
    k = 0;
    while (bus.cpu_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin to = 1'b1; return; end
    bus.cpu_req = 1'b1; bus.cpu_rw = rw; bus.cpu_addr = a; bus.cpu_wdata = wd;
    rw0 = rw_hi_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.cpu_addr = 10'($urandom);
    bus.cpu_wdata = $urandom;
    k = 0;
    while (bus.cpu_done !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) to = 1'b1;
    lat = k + 1;
    rd  = bus.cpu_rdata;
    rwc = rw_hi_cnt - rw0;
  endtask

  task automatic test_reset();
    bus.cpu_req = 1'b0; bus.cpu_rw = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    total++; if (bus.cpu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.cpu_ready); end
    total++; if (bus.cpu_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.cpu_done); end
    total++; if (bus.cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.cpu_rdata); end
    total++; if (bus.mem_read_write !== 1'b0) begin bad++; $display("FAIL reset_mem_rw got=%b exp=0", bus.mem_read_write); end
    total++; if (bus.mem_address !== 10'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_address); end
    total++; if (bus.mem_write_data !== 128'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_write_data); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.cpu_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", bus.cpu_ready); end
  endtask

  task automatic test_read_path();
    logic [9:0] addrs [6];
    logic [31:0] rd, erd;
    int lat, rwc, elat;
    bit to, eh;
    addrs = '{10'h000, 10'h004, 10'h040, 10'h080, 10'h000, 10'h044};
    for (int i = 0; i < 6; i++) begin
      access(1'b0, addrs[i], 32'h0, rd, lat, rwc, to);
      model(1'b0, addrs[i], 32'h0, eh, erd);
      elat = eh ? 2 : 3 + int'(MEM_LAT);
      total++; if (to) begin bad++; $display("FAIL read_timeout addr=%h", addrs[i]); end
      total++; if (rd !== erd) begin bad++; $display("FAIL read_rdata addr=%h got=%h exp=%h", addrs[i], rd, erd); end
      total++; if (lat !== elat) begin bad++; $display("FAIL read_latency addr=%h got=%0d exp=%0d", addrs[i], lat, elat); end
      total++; if (rwc !== 0) begin bad++; $display("FAIL read_mem_rw addr=%h got=%0d exp=0", addrs[i], rwc); end
    end
  endtask

  // Write hit and write miss (top address, empty set) through memory and back
  task automatic test_write_through();
    bit          rws [5];
    logic [9:0]  addrs [5];
    logic [31:0] wds [5];
    logic [31:0] rd, erd;
    int lat, rwc, elat, erwc;
    bit to, eh;
    rws   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    addrs = '{10'h008, 10'h008, 10'h008, 10'h3FC, 10'h3FC};
    wds   = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h5, 32'h0};
    for (int i = 0; i < 5; i++) begin
      access(rws[i], addrs[i], wds[i], rd, lat, rwc, to);
      model(rws[i], addrs[i], wds[i], eh, erd);
      elat = (eh && !rws[i]) ? 2 : 3 + int'(MEM_LAT);
      erwc = rws[i] ? int'(MEM_LAT) : 0;
      total++; if (to) begin bad++; $display("FAIL wt_timeout addr=%h", addrs[i]); end
      total++; if (lat !== elat) begin bad++; $display("FAIL wt_latency addr=%h got=%0d exp=%0d", addrs[i], lat, elat); end
      total++; if (rwc !== erwc) begin bad++; $display("FAIL wt_mem_rw_cycles addr=%h got=%0d exp=%0d", addrs[i], rwc, erwc); end
      if (rws[i]) begin
        total++; if (mem[addrs[i][9:2]] !== erd) begin bad++; $display("FAIL wt_mem_word addr=%h got=%h exp=%h", addrs[i], mem[addrs[i][9:2]], erd); end
      end else begin
        total++; if (rd !== erd) begin bad++; $display("FAIL wt_rdata addr=%h got=%h exp=%h", addrs[i], rd, erd); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd;
    int lat, rwc, elat, k;
    bit to, eh;
    k = 0;
    while (bus.cpu_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 10'h010;
    @(posedge clk);
    @(negedge clk); bus.cpu_req = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_address !== 10'h010) begin bad++; $display("FAIL midrd_addr got=%h exp=010", bus.mem_address); end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (bus.cpu_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", bus.cpu_ready); end
    total++; if (bus.cpu_rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", bus.cpu_rdata); end
    total++; if (bus.mem_address !== 10'h0) begin bad++; $display("FAIL midrst_mem_addr got=%h exp=0", bus.mem_address); end
    total++; if (bus.mem_write_data !== 128'h0) begin bad++; $display("FAIL midrst_mem_wdata got=%h exp=0", bus.mem_write_data); end
    total++; if ({bus.cpu_done, bus.mem_read_write} !== 2'b00) begin bad++; $display("FAIL midrst_done_rw got=%b exp=00", {bus.cpu_done, bus.mem_read_write}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 10'h010, 32'h0, rd, lat, rwc, to);
    model(1'b0, 10'h010, 32'h0, eh, erd);
    elat = eh ? 2 : 3 + int'(MEM_LAT);
    total++; if (to) begin bad++; $display("FAIL postrst_timeout"); end
    total++; if (rd !== erd) begin bad++; $display("FAIL postrst_rdata got=%h exp=%h", rd, erd); end
    total++; if (lat !== elat) begin bad++; $display("FAIL postrst_latency got=%0d exp=%0d", lat, elat); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, wd;
    logic [9:0] a;
    logic [3:0] t;
    int lat, rwc, elat, erwc, pick, diffs;
    bit to, eh, rw;
    for (int i = 0; i < 300; i++) begin
      pick = int'($urandom_range(0, 3));
      t  = (pick == 3) ? 4'hF : 4'(pick);
      a  = {t, 2'($urandom), 2'($urandom), 2'($urandom)};
      rw = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      access(rw, a, wd, rd, lat, rwc, to);
      model(rw, a, wd, eh, erd);
      elat = (eh && !rw) ? 2 : 3 + int'(MEM_LAT);
      erwc = rw ? int'(MEM_LAT) : 0;
      total++; if (to) begin bad++; $display("FAIL rand_timeout i=%0d addr=%h", i, a); end
      total++; if (lat !== elat) begin bad++; $display("FAIL rand_latency i=%0d addr=%h rw=%b got=%0d exp=%0d", i, a, rw, lat, elat); end
      total++; if (rwc !== erwc) begin bad++; $display("FAIL rand_mem_rw_cycles i=%0d addr=%h got=%0d exp=%0d", i, a, rwc, erwc); end
      if (!rw) begin
        total++; if (rd !== erd) begin bad++; $display("FAIL rand_rdata i=%0d addr=%h got=%h exp=%h", i, a, rd, erd); end
      end
    end
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    total++; if (diffs !== 0) begin bad++; $display("FAIL rand_memory_image got=%0d differing words exp=0", diffs); end
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    logic [9:0] addrs [4];
    logic [31:0] rd, erd;
    int lat, rwc;
    bit to, eh;
    addrs = '{10'h040, 10'h080, 10'h000, 10'h044};
    @(negedge clk); rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, addrs[i], 32'h0, rd, lat, rwc, to);
      model(1'b0, addrs[i], 32'h0, eh, erd);
      total++; if (to) begin bad++; $display("FAIL stats_timeout addr=%h", addrs[i]); end
    end
    total++; if (hit_count !== 16'(n_hit)) begin bad++; $display("FAIL stats_hits got=%0d exp=%0d", hit_count, n_hit); end
    total++; if (miss_count !== 16'(n_miss)) begin bad++; $display("FAIL stats_misses got=%0d exp=%0d", miss_count, n_miss); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i + 1);
    test_reset();
    test_read_path();
    test_write_through();
    test_reset_mid();
    test_random();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
